// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative SPARC UMUL/SMUL/UDIV/SDIV (plus cc forms) for the execute stage.
// Multiply is radix-2 shift-add on magnitudes; divide is restoring on magnitudes.
// Both take 32 iteration edges; done pulses the cycle after the last one.
// Optional feature: define MULDIV_DIV_EN to build the divider. Without it, divide
// opcodes complete on the next edge with unimp set and nothing written.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [5:0]       op3,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] Y_in,
  output logic             ex_ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] Y_out,
  output logic             Y_we,
  output logic             icc_n,
  output logic             icc_z,
  output logic             icc_v,
  output logic             icc_c,
  output logic             icc_we,
  output logic             div_zero,
  output logic             unimp
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             sgn_q, sgn_d, cc_q, cc_d, neg_q, neg_d;
  logic [WIDTH-1:0] opa_q, opa_d;       // multiplicand / divisor magnitude
  logic [W2-1:0]    acc_q, acc_d;       // mul: {hi, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0] res_q, res_d, yout_q, yout_d;
  logic             ywe_q, ywe_d, iccwe_q, iccwe_d;
  logic             n_q, n_d, z_q, z_d, v_q, v_d;
  logic             divz_q, divz_d, unimp_q, unimp_d;

  // op3 decode: bit0 = signed, bit4 = cc variant
  logic is_mul, is_div, go;
  assign is_mul = !op3[5] && (op3[3:1] == 3'b101);
  assign is_div = !op3[5] && (op3[3:1] == 3'b111);
  assign go     = start && (is_mul || is_div) && !kill;

  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (op3[0] && valA[WIDTH-1]) ? -valA : valA;
  assign b_mag = (op3[0] && valB[WIDTH-1]) ? -valB : valB;

  // one shift-add step; the 33-bit sum keeps the carry out of the high half
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next, prod;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod     = neg_q ? -mul_next : mul_next;

`ifdef MULDIV_DIV_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             ovf_pre_q, ovf_pre_d, dz_pend_q, dz_pend_d;
  logic [W2-1:0]    dvd, dvd_mag, div_next;
  logic [WIDTH:0]   div_try;
  logic [WIDTH-1:0] quo, quo_res;
  logic             div_ovf;

  assign dvd     = {Y_in, valA};
  assign dvd_mag = (op3[0] && Y_in[WIDTH-1]) ? -dvd : dvd;
  // restoring step: remainder stays below the divisor, so a borrow shows in bit WIDTH
  assign div_try  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opa_q};
  assign div_next = div_try[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                   : {div_try[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo      = div_next[WIDTH-1:0];
  assign div_ovf  = ovf_pre_q || (sgn_q && (neg_q ? (quo > SMIN) : (quo > SMAX)));
  assign quo_res  = div_ovf ? (sgn_q ? (neg_q ? SMIN : SMAX) : {WIDTH{1'b1}})
                            : (neg_q ? -quo : quo);
`else
  logic unused_div;
  assign unused_div = ^Y_in;
`endif

  // next-state, iteration and result capture
  always_comb begin
    state_d = state_q;  cnt_d  = cnt_q;   sgn_d   = sgn_q;   cc_d = cc_q;
    neg_d   = neg_q;    opa_d  = opa_q;   acc_d   = acc_q;
    res_d   = res_q;    yout_d = yout_q;  ywe_d   = ywe_q;   iccwe_d = iccwe_q;
    n_d     = n_q;      z_d    = z_q;     v_d     = v_q;
    divz_d  = divz_q;   unimp_d = unimp_q;
`ifdef MULDIV_DIV_EN
    ovf_pre_d = ovf_pre_q;
    dz_pend_d = dz_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (go) begin
          cnt_d = '0;
          sgn_d = op3[0];
          cc_d  = op3[4];
          if (is_mul) begin
            opa_d   = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            neg_d   = op3[0] && (valA[WIDTH-1] ^ valB[WIDTH-1]);
            state_d = MUL;
          end else begin
`ifdef MULDIV_DIV_EN
            opa_d     = b_mag;
            acc_d     = dvd_mag;
            neg_d     = op3[0] && (Y_in[WIDTH-1] ^ valB[WIDTH-1]);
            ovf_pre_d = dvd_mag[W2-1:WIDTH] >= b_mag;
            dz_pend_d = (valB == '0);
            state_d   = DIV;
`else
            res_d   = '0;   ywe_d = 1'b0;  iccwe_d = 1'b0;
            divz_d  = 1'b0; unimp_d = 1'b1;
            n_d     = 1'b0; z_d = 1'b1;    v_d = 1'b0;
            state_d = DONE;
`endif
          end
        end
      end
      MUL: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res_d   = prod[WIDTH-1:0];
            yout_d  = prod[W2-1:WIDTH];
            ywe_d   = 1'b1;
            iccwe_d = cc_q;
            n_d     = prod[WIDTH-1];
            z_d     = (prod[WIDTH-1:0] == '0);
            v_d     = 1'b0;
            divz_d  = 1'b0;
            unimp_d = 1'b0;
            state_d = DONE;
          end
        end
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        if (kill) begin
          state_d = IDLE;
        end else if (dz_pend_q) begin
          res_d   = '0;   ywe_d = 1'b0;  iccwe_d = 1'b0;
          divz_d  = 1'b1; unimp_d = 1'b0;
          n_d     = 1'b0; z_d = 1'b1;    v_d = 1'b0;
          state_d = DONE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res_d   = quo_res;
            ywe_d   = 1'b0;
            iccwe_d = cc_q;
            n_d     = quo_res[WIDTH-1];
            z_d     = (quo_res == '0);
            v_d     = div_ovf;
            divz_d  = 1'b0;
            unimp_d = 1'b0;
            state_d = DONE;
          end
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;  cnt_q  <= '0;   sgn_q   <= 1'b0;  cc_q <= 1'b0;
      neg_q   <= 1'b0;  opa_q  <= '0;   acc_q   <= '0;
      res_q   <= '0;    yout_q <= '0;   ywe_q   <= 1'b0;  iccwe_q <= 1'b0;
      n_q     <= 1'b0;  z_q    <= 1'b0; v_q     <= 1'b0;
      divz_q  <= 1'b0;  unimp_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      ovf_pre_q <= 1'b0;
      dz_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  cnt_q  <= cnt_d;   sgn_q   <= sgn_d;   cc_q <= cc_d;
      neg_q   <= neg_d;    opa_q  <= opa_d;   acc_q   <= acc_d;
      res_q   <= res_d;    yout_q <= yout_d;  ywe_q   <= ywe_d;   iccwe_q <= iccwe_d;
      n_q     <= n_d;      z_q    <= z_d;     v_q     <= v_d;
      divz_q  <= divz_d;   unimp_q <= unimp_d;
`ifdef MULDIV_DIV_EN
      ovf_pre_q <= ovf_pre_d;
      dz_pend_q <= dz_pend_d;
`endif
    end
  end

  // a kill in DONE suppresses the pulse and every write enable with it
  assign done     = (state_q == DONE) && !kill;
  assign ex_ready = (state_q == IDLE) ? !go : (state_q == DONE);
  assign result   = res_q;
  assign Y_out    = yout_q;
  assign Y_we     = done && ywe_q;
  assign icc_we   = done && iccwe_q;
  assign div_zero = done && divz_q;
  assign unimp    = done && unimp_q;
  assign icc_n    = n_q;
  assign icc_z    = z_q;
  assign icc_v    = v_q;
  assign icc_c    = 1'b0;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed and random ops against an arithmetic reference model.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [5:0]  op3;
  logic [31:0] valA, valB, Y_in;
  logic        ex_ready, done, Y_we, icc_n, icc_z, icc_v, icc_c, icc_we, div_zero, unimp;
  logic [31:0] result, Y_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res;

  logic [5:0] mulops [4] = '{6'h0A, 6'h0B, 6'h1A, 6'h1B};
  logic [5:0] divops [4] = '{6'h0E, 6'h0F, 6'h1E, 6'h1F};

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .op3(op3),
    .valA(valA), .valB(valB), .Y_in(Y_in), .ex_ready(ex_ready), .done(done),
    .result(result), .Y_out(Y_out), .Y_we(Y_we), .icc_n(icc_n), .icc_z(icc_z),
    .icc_v(icc_v), .icc_c(icc_c), .icc_we(icc_we), .div_zero(div_zero), .unimp(unimp)
  );

  typedef struct {
    logic [31:0] res, yv;
    logic        ywe, iccwe, n, z, v, dz, un;
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, b, y);
    exp_t   e;
    bit     is_mul, sg, cc;
    longint sa, sb, sp;
    logic [63:0] p;
`ifdef MULDIV_DIV_EN
    logic [63:0] um, q;
    logic [31:0] ud;
    bit          neg, ovf;
`endif
    is_mul = (op == 6'h0A) || (op == 6'h0B) || (op == 6'h1A) || (op == 6'h1B);
    sg     = (op == 6'h0B) || (op == 6'h1B) || (op == 6'h0F) || (op == 6'h1F);
    cc     = (op >= 6'h1A);
    e.res = 0; e.yv = 0; e.ywe = 0; e.iccwe = 0; e.n = 0; e.z = 0; e.v = 0;
    e.dz = 0; e.un = 0; e.lat = 33;
    if (is_mul) begin
      if (sg) begin
        sa = $signed(a); sb = $signed(b); sp = sa * sb; p = sp;
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      e.res = p[31:0]; e.yv = p[63:32]; e.ywe = 1; e.iccwe = cc;
    end else begin
`ifdef MULDIV_DIV_EN
      if (b == 0) begin
        e.dz = 1; e.lat = 2;
      end else begin
        um = {y, a};
        if (sg && y[31]) um = -um;
        ud  = (sg && b[31]) ? -b : b;
        q   = um / {32'b0, ud};
        neg = sg && (y[31] ^ b[31]);
        if (!sg)     ovf = q > 64'hFFFF_FFFF;
        else if (neg) ovf = q > 64'h8000_0000;
        else          ovf = q > 64'h7FFF_FFFF;
        if (ovf) e.res = !sg ? 32'hFFFF_FFFF : (neg ? 32'h8000_0000 : 32'h7FFF_FFFF);
        else     e.res = neg ? -q[31:0] : q[31:0];
        e.v = ovf; e.iccwe = cc;
      end
`else
      e.un = 1; e.lat = 1;
`endif
    end
    e.n = e.res[31];
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s op3=%h A=%h B=%h Y=%h: got %h want %h", tag, op3, valA, valB, Y_in, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run(input logic [5:0] op, input logic [31:0] a, b, y);
    exp_t e;
    int   cyc;
    bit   rdy_bad;
    e = model(op, a, b, y);
    op3 = op; valA = a; valB = b; Y_in = y; start = 1'b1;
    #1;
    chk("ready_at_start", ex_ready, 0);
    step();
    start = 1'b0;
    cyc = 1; rdy_bad = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (ex_ready !== 1'b0) rdy_bad = 1;
      step();
      cyc++;
    end
    chk("latency", cyc, e.lat);
    chk("ready_busy", rdy_bad, 0);
    chk("ready_done", ex_ready, 1);
    chk("result", result, e.res);
    chk("y_we", Y_we, e.ywe);
    if (e.ywe) chk("y_out", Y_out, e.yv);
    chk("icc_we", icc_we, e.iccwe);
    if (e.iccwe) begin
      chk("icc_n", icc_n, e.n);
      chk("icc_z", icc_z, e.z);
      chk("icc_v", icc_v, e.v);
    end
    chk("icc_c", icc_c, 0);
    chk("div_zero", div_zero, e.dz);
    chk("unimp", unimp, e.un);
    last_res = e.res;
    step();
    chk("done_pulse", done, 0);
    chk("result_held", result, e.res);
  endtask

  task automatic abort_at_10(input bit use_reset);
    bit seen;
    op3 = 6'h0A; valA = 32'h1234_5678; valB = 32'h9ABC_DEF0; Y_in = 0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    if (use_reset) reset = 1'b1; else kill = 1'b1;
    #1;
    chk("abort_no_done", done, 0);
    step();
    reset = 1'b0; kill = 1'b0;
    #1;
    chk("abort_ready", ex_ready, 1);
    chk("abort_done", done, 0);
    if (use_reset) begin
      chk("rst_result", result, 0);
      chk("rst_yout", Y_out, 0);
      chk("rst_flags", {icc_n, icc_z, icc_v, icc_c, icc_we, Y_we, div_zero, unimp}, 0);
      last_res = 0;
    end else begin
      chk("kill_result_kept", result, last_res);
    end
    seen = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) seen = 1;
    end
    chk("abort_never_done", seen, 0);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] a, b, y;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op3 = 0; valA = 0; valB = 0; Y_in = 0;
    last_res = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_result", result, 0);
    chk("reset_yout", Y_out, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", ex_ready, 1);
    chk("reset_flags", {icc_n, icc_z, icc_v, icc_c, icc_we, Y_we, div_zero, unimp}, 0);

    // unrecognised opcode never starts
    op3 = 6'h00; start = 1'b1;
    #1;
    chk("bad_op_ready", ex_ready, 1);
    step();
    start = 1'b0;
    chk("bad_op_done", done, 0);
    chk("bad_op_ready2", ex_ready, 1);

    // directed multiplies
    run(6'h0A, 32'hFFFF_FFFF, 32'd2, 0);
    chk("tp_umul_res", result, 32'hFFFF_FFFE);
    chk("tp_umul_y", Y_out, 32'h0000_0001);
    run(6'h1B, 32'hFFFF_FFFD, 32'd5, 0);
    chk("tp_smulcc_res", result, 32'hFFFF_FFF1);
    chk("tp_smulcc_y", Y_out, 32'hFFFF_FFFF);
    chk("tp_smulcc_n", icc_n, 1);
    run(6'h0A, 32'd3, 32'd4, 0);
    chk("tp_umul12", result, 32'd12);
    run(6'h1B, 32'h8000_0000, 32'h8000_0000, 0);
    run(6'h1B, 32'h8000_0000, 32'h0000_0001, 0);
    run(6'h1A, 32'h0000_0000, 32'hDEAD_BEEF, 0);

    for (int i = 0; i < 16; i++) begin
      run(mulops[$urandom_range(0, 3)], $urandom, $urandom, $urandom);
    end

`ifdef MULDIV_DIV_EN
    run(6'h1E, 32'd100, 32'd7, 0);
    chk("tp_udiv14", result, 32'd14);
    run(6'h1E, 32'd0, 32'd1, 32'd1);
    chk("tp_udiv_ovf", result, 32'hFFFF_FFFF);
    run(6'h0F, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFF);
    chk("tp_sdiv_neg", result, 32'hFFFF_FFF2);
    run(6'h0F, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF);
    run(6'h1F, 32'h8000_0000, 32'd1, 32'd0);
    run(6'h1F, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF);
    run(6'h1F, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) begin
      op = divops[$urandom_range(0, 3)];
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1, 2:    b = $urandom_range(1, 1000);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) y = $urandom;
      else if (op[0])                 y = {32{a[31]}};
      else                            y = $urandom_range(0, 2);
      run(op, a, b, y);
    end
`else
    run(6'h0E, 32'd100, 32'd7, 0);
    run(6'h1F, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFF);
    run(6'h0A, 32'd3, 32'd4, 0);
    chk("nodiv_umul12", result, 32'd12);
`endif

    abort_at_10(1'b0);
    abort_at_10(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
